// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto one registered-read memory port
module mem_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [1:0]          d_wty,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_resp_data,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [1:0]          mem_wty,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int SW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WORD_LEN-1:0] addr_q, wdata_q;
  logic [1:0] wty_q;
  logic own_d_q, wen_q, ival_q, dval_q;
  logic open_w, grant_i, acc_i, acc_d, acc;
  // grant selection and next-state; rst closes the accept window so nothing is granted in the reset cycle
  always_comb begin
    open_w   = !rst && state_q != ISSUE;
    grant_i  = i_req_valid && (!d_req_valid || starve_q == LIM);
    acc_i    = open_w && grant_i;
    acc_d    = open_w && d_req_valid && !grant_i;
    acc      = acc_i || acc_d;
    state_d  = acc ? ISSUE : state_q == ISSUE ? RESP : IDLE;
    starve_d = acc_i ? '0 : !acc_d ? starve_q : !i_req_valid ? '0 : starve_q == LIM ? starve_q : starve_q + 1'b1;
  end
  // FSM, request latch and registered response/write strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wty_q    <= '0;
      own_d_q  <= 1'b0;
      wen_q    <= 1'b0;
      ival_q   <= 1'b0;
      dval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wen_q    <= acc_d && d_wen;
      ival_q   <= state_q == ISSUE && !own_d_q;
      dval_q   <= state_q == ISSUE && own_d_q;
      if (acc) begin
        addr_q  <= acc_d ? d_addr : i_addr;
        wdata_q <= acc_d ? d_wdata : '0;
        wty_q   <= acc_d ? d_wty : 2'd2;
        own_d_q <= acc_d;
      end
    end
  end
  assign i_req_ready  = acc_i;
  assign d_req_ready  = acc_d;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wty      = wty_q;
  assign mem_wen      = wen_q && !rst;
  assign i_resp_valid = ival_q && !rst;
  assign d_resp_valid = dval_q && !rst;
  assign i_resp_data  = mem_rdata;
  assign d_resp_data  = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, data/address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_req_valid input 1, i_req_ready output 1, i_addr input WORD_LEN: instruction-fetch request channel.
REQ-006 SHALL have ports i_resp_valid output 1, i_resp_data output WORD_LEN: fetch response.
REQ-007 SHALL have ports d_req_valid input 1, d_req_ready output 1, d_addr input WORD_LEN, d_wen input 1, d_wty input 2 (0 byte, 1 half, 2 word), d_wdata input WORD_LEN: data request channel.
REQ-008 SHALL have ports d_resp_valid output 1, d_resp_data output WORD_LEN: data response/write ack.
REQ-009 SHALL have ports mem_addr output WORD_LEN, mem_wen output 1, mem_wty output 2, mem_wdata output WORD_LEN, mem_rdata input WORD_LEN: single shared memory port; memory registers read data 1 cycle after address is sampled, read-before-write.

Function
REQ-010 SHALL implement states IDLE, ISSUE, RESP, with one access in flight.
REQ-011 SHALL accept a request (valid && ready) only in IDLE or RESP; ready SHALL be 0 in ISSUE.
REQ-012 SHALL assert ready combinationally to at most one requester per cycle: the granted one, and only if its valid is high.
REQ-013 Grant rule: data wins when both valid, unless starve counter == STARVE_LIMIT and i_req_valid, then fetch wins.
REQ-014 Starve counter: +1 on each data accept while i_req_valid high; cleared on fetch accept or on data accept with i_req_valid low; saturates at STARVE_LIMIT.
REQ-015 On accept SHALL latch addr, wen (0 for fetch), wty, wdata, and owner (I/D); next state ISSUE.
REQ-016 In ISSUE SHALL drive mem_addr/mem_wty/mem_wdata from latch and mem_wen = latched wen; next state RESP unconditionally.
REQ-017 mem_wen SHALL be 0 in every state except ISSUE.
REQ-018 Outside ISSUE, mem_addr SHALL hold the last latched address (harmless read).
REQ-019 In RESP SHALL pulse owner's resp_valid for exactly one cycle with resp_data = mem_rdata; the other resp_valid SHALL stay 0.
REQ-020 For a write, d_resp_data SHALL be the pre-write word; d_resp_valid serves as the write ack.
REQ-021 In RESP a new accept SHALL go to ISSUE; otherwise to IDLE.
REQ-022 Latency: accept at cycle N -> resp_valid at cycle N+2; peak throughput one access per 2 cycles.
REQ-023 Requester dropping valid before accept SHALL be legal; no grant recorded.
REQ-024 Inputs not accepted SHALL have no effect on memory.

Reset
REQ-025 While rst high at a posedge: state IDLE, starve counter 0, latches 0, owner I.
REQ-026 During and after reset cycle: i/d_req_ready, i/d_resp_valid, mem_wen SHALL be 0 until the next accept; in-flight access dropped, no response issued.
REQ-027 Reset asserted in ISSUE of a write SHALL still suppress mem_wen in the reset cycle (write not committed).

Verification
REQ-028 Fetch only: i_addr=0x10, mem word 0x00000013 -> i_req_ready at N, mem_addr=0x10 at N+1, i_resp_valid & i_resp_data=0x00000013 at N+2.
REQ-029 Both valid every cycle, STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating; accepts every 2 cycles.
REQ-030 Data write d_addr=0x20, d_wen=1, d_wty=2, d_wdata=0xDEADBEEF, old 0x0 -> mem_wen=1 only at N+1, d_resp_data=0x0 at N+2; subsequent read of 0x20 returns 0xDEADBEEF.
REQ-031 Back-to-back: data read accepted in RESP of prior fetch -> no idle cycle; i_resp_valid and d_resp_valid never high together.
REQ-032 rst asserted in ISSUE of write to 0x30 -> mem_wen=0, no d_resp_valid, 0x30 unchanged, next request served normally.
REQ-033 i_req_valid pulsed one cycle while data granted -> no fetch grant, starve counter cleared by next data accept with i_req_valid low.
